// File: rtl/mux_seq_pkg.sv
// Shared definitions for the mux select sequencer: default sizing and FSM states.
package mux_seq_pkg;

  localparam int unsigned DFLT_NUM_INPUTS = 7;
  localparam int unsigned DFLT_SEL_W      = 3;
  localparam int unsigned DFLT_DIV_W      = 8;
  localparam int unsigned LAST_SEL        = DFLT_NUM_INPUTS - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mux_select_sequencer_rate_divider.sv
// Loadable down-counter used to time how long each mux select is held.
module rate_divider #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [DIV_W-1:0] count_q;

  // Load wins over decrement; the counter saturates at zero instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_q <= count_q - DIV_W'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/mux_select_sequencer.sv
// Latches a pattern on start and steps the mux select 0..NUM_INPUTS-1, holding each for a programmable period.
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = DFLT_NUM_INPUTS,
  parameter int unsigned SEL_W      = DFLT_SEL_W,
  parameter int unsigned DIV_W      = DFLT_DIV_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_INPUTS-1:0] pattern,
  input  logic [DIV_W-1:0]      period,
  output logic [NUM_INPUTS-1:0] mux_data,
  output logic [SEL_W-1:0]      mux_select,
  output logic                  step,
  output logic                  busy,
  output logic                  done
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_INPUTS - 1);

  state_e                  state_q, state_d;
  logic [NUM_INPUTS-1:0]   mux_data_q, mux_data_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    step_q, step_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic [DIV_W-1:0]        held_q, held_d;

  logic                    cnt_load;
  logic                    cnt_en;
  logic [DIV_W-1:0]        cnt_val;
  logic                    cnt_zero;
  logic [DIV_W-1:0]        eff_period;

  assign eff_period = (period == '0) ? DIV_W'(1) : period;

  rate_divider #(
    .DIV_W (DIV_W)
  ) u_hold_cnt (
    .clk_i      (clk),
    .rst_i      (reset),
    .load_i     (cnt_load),
    .en_i       (cnt_en),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      mux_data_q <= '0;
      sel_q      <= '0;
      step_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      held_q     <= '0;
    end else begin
      state_q    <= state_d;
      mux_data_q <= mux_data_d;
      sel_q      <= sel_d;
      step_q     <= step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      held_q     <= held_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    mux_data_d = mux_data_q;
    sel_d      = sel_q;
    step_d     = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    held_d     = held_q;
    cnt_load   = 1'b0;
    cnt_en     = 1'b0;
    cnt_val    = '0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          mux_data_d = pattern;
          held_d     = eff_period;
          sel_d      = '0;
          step_d     = 1'b1;
          busy_d     = 1'b1;
          cnt_load   = 1'b1;
          cnt_val    = eff_period - DIV_W'(1);
        end else begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sel_d   = '0;
        end
      end
      RUN: begin
        // abort outranks both the step advance and sweep completion
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          sel_d   = '0;
        end else if (!cnt_zero) begin
          cnt_en = 1'b1;
        end else if (sel_q < LAST_IDX) begin
          sel_d    = sel_q + SEL_W'(1);
          step_d   = 1'b1;
          cnt_load = 1'b1;
          cnt_val  = held_q - DIV_W'(1);
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          sel_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

  assign mux_data   = mux_data_q;
  assign mux_select = sel_q;
  assign step       = step_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench: per-cycle expectations derived from the sweep timing rules.
module tb_mux_select_sequencer;

  localparam int NUM = 7;

  logic       clk;
  logic       reset;
  logic       start;
  logic       abort;
  logic [6:0] pattern;
  logic [7:0] period;
  logic [6:0] mux_data;
  logic [2:0] mux_select;
  logic       step;
  logic       busy;
  logic       done;

  int errors;
  int checks;

  mux_select_sequencer #(
    .NUM_INPUTS (7),
    .SEL_W      (3),
    .DIV_W      (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .pattern    (pattern),
    .period     (period),
    .mux_data   (mux_data),
    .mux_select (mux_select),
    .step       (step),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Expected {busy, done, step, sel} at t cycles after an accepted start.
  function automatic logic [5:0] model(input int t, input int p);
    int ep;
    ep = (p == 0) ? 1 : p;
    if (t < NUM * ep)       model = {1'b1, 1'b0, ((t % ep) == 0), 3'(t / ep)};
    else if (t == NUM * ep) model = 6'b010000;
    else                    model = 6'b000000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [5:0] got;
    reset = 1'b1;
    repeat (2) tick();
    got = {busy, done, step, mux_select};
    checks++;
    if (got !== 6'b0 || mux_data !== 7'h00) begin
      errors++;
      $display("FAIL reset_init: got ctl=%b data=%h, required ctl=000000 data=00", got, mux_data);
    end
    reset   = 1'b0;
    pattern = 7'h7F;
    period  = 8'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    got = {busy, done, step, mux_select};
    checks++;
    if (got !== 6'b0 || mux_data !== 7'h00) begin
      errors++;
      $display("FAIL reset_async: got ctl=%b data=%h, required ctl=000000 data=00", got, mux_data);
    end
    tick();
    reset = 1'b0;
    tick();
    got = {busy, done, step, mux_select};
    checks++;
    if (got !== 6'b0 || mux_data !== 7'h00) begin
      errors++;
      $display("FAIL reset_release: got ctl=%b data=%h, required ctl=000000 data=00", got, mux_data);
    end
  endtask

  task automatic test_basic();
    logic [5:0] exp;
    logic [6:0] serial_exp;
    logic [6:0] pat;
    serial_exp = 7'b1011001;
    pat        = 7'b1011001;
    pattern    = pat;
    period     = 8'd1;
    start      = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= NUM + 1; t++) begin
      exp = model(t, 1);
      checks++;
      if ({busy, done, step, mux_select} !== exp || mux_data !== pat) begin
        errors++;
        $display("FAIL basic t=%0d: got ctl=%b data=%h, required ctl=%b data=%h",
                 t, {busy, done, step, mux_select}, mux_data, exp, pat);
      end
      if (t < NUM) begin
        checks++;
        if (mux_data[mux_select] !== serial_exp[t]) begin
          errors++;
          $display("FAIL basic_serial t=%0d: got bit=%b, required bit=%b",
                   t, mux_data[mux_select], serial_exp[t]);
        end
      end
      tick();
    end
  endtask

  task automatic test_hold(input int p, input logic [6:0] pat, input string name);
    logic [5:0] exp;
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    pattern  = pat;
    period   = 8'(p);
    start    = 1'b1;
    tick();
    start   = 1'b0;
    pattern = ~pat;
    period  = 8'd9;
    for (int t = 0; t <= NUM * ((p == 0) ? 1 : p) + 2; t++) begin
      exp = model(t, p);
      busy_cnt += int'(busy);
      done_cnt += int'(done);
      checks++;
      if ({busy, done, step, mux_select} !== exp || mux_data !== pat) begin
        errors++;
        $display("FAIL %s t=%0d: got ctl=%b data=%h, required ctl=%b data=%h",
                 name, t, {busy, done, step, mux_select}, mux_data, exp, pat);
      end
      tick();
    end
    checks++;
    if (busy_cnt != NUM * ((p == 0) ? 1 : p) || done_cnt != 1) begin
      errors++;
      $display("FAIL %s_counts: got busy=%0d done=%0d, required busy=%0d done=1",
               name, busy_cnt, done_cnt, NUM * ((p == 0) ? 1 : p));
    end
  endtask

  task automatic test_abort();
    logic [5:0] exp;
    logic [6:0] last;
    logic [6:0] pat;
    last  = mux_data;
    abort = 1'b1;
    repeat (2) tick();
    abort = 1'b0;
    checks++;
    if ({busy, done, step, mux_select} !== 6'b0 || mux_data !== last) begin
      errors++;
      $display("FAIL abort_idle: got ctl=%b data=%h, required ctl=000000 data=%h",
               {busy, done, step, mux_select}, mux_data, last);
    end
    pat     = 7'(($urandom & 32'h7F));
    pattern = pat;
    period  = 8'd2;
    start   = 1'b1;
    abort   = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    for (int t = 0; t <= 6; t++) begin
      exp = model(t, 2);
      checks++;
      if ({busy, done, step, mux_select} !== exp || mux_data !== pat) begin
        errors++;
        $display("FAIL abort_run t=%0d: got ctl=%b data=%h, required ctl=%b data=%h",
                 t, {busy, done, step, mux_select}, mux_data, exp, pat);
      end
      if (t < 6) tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    for (int k = 0; k < 20; k++) begin
      checks++;
      if ({busy, done, step, mux_select} !== 6'b0 || mux_data !== pat) begin
        errors++;
        $display("FAIL abort_after k=%0d: got ctl=%b data=%h, required ctl=000000 data=%h",
                 k, {busy, done, step, mux_select}, mux_data, pat);
      end
      tick();
    end
    test_hold(2, 7'(($urandom & 32'h7F)), "abort_resweep");
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    logic [6:0] lat;
    logic [6:0] nxt;
    lat     = 7'(($urandom & 32'h7F));
    nxt     = lat;
    pattern = lat;
    period  = 8'd1;
    start   = 1'b1;
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int t = 0; t < 8; t++) begin
        exp = model(t, 1);
        checks++;
        if ({busy, done, step, mux_select} !== exp || mux_data !== lat) begin
          errors++;
          $display("FAIL b2b f=%0d t=%0d: got ctl=%b data=%h, required ctl=%b data=%h",
                   f, t, {busy, done, step, mux_select}, mux_data, exp, lat);
        end
        if (t == 3) begin
          nxt     = 7'(($urandom & 32'h7F));
          pattern = nxt;
        end
        if (t == 7) begin
          if (f < 2) lat = nxt;
          else       start = 1'b0;
        end
        tick();
      end
    end
    checks++;
    if ({busy, done, step, mux_select} !== 6'b0 || mux_data !== lat) begin
      errors++;
      $display("FAIL b2b_end: got ctl=%b data=%h, required ctl=000000 data=%h",
               {busy, done, step, mux_select}, mux_data, lat);
    end
  endtask

  task automatic test_random();
    logic [5:0] exp;
    logic [6:0] pat;
    int p;
    for (int n = 0; n < 8; n++) begin
      p       = int'($urandom_range(0, 5));
      pat     = 7'(($urandom & 32'h7F));
      pattern = pat;
      period  = 8'(p);
      start   = 1'b1;
      tick();
      for (int t = 0; t <= NUM * ((p == 0) ? 1 : p) + 1; t++) begin
        exp = model(t, p);
        checks++;
        if ({busy, done, step, mux_select} !== exp || mux_data !== pat) begin
          errors++;
          $display("FAIL random n=%0d p=%0d t=%0d: got ctl=%b data=%h, required ctl=%b data=%h",
                   n, p, t, {busy, done, step, mux_select}, mux_data, exp, pat);
        end
        if (t < NUM * ((p == 0) ? 1 : p)) begin
          start   = 1'($urandom_range(0, 1));
          pattern = 7'(($urandom & 32'h7F));
          period  = 8'($urandom_range(0, 255));
        end else begin
          start = 1'b0;
        end
        tick();
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    period  = '0;
    test_reset();
    test_basic();
    test_hold(3, 7'h55, "hold3");
    test_hold(0, 7'h2A, "period0");
    test_abort();
    test_back_to_back();
    test_random();
    test_hold(255, 7'h63, "hold255");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
